sparse_pair_sched: RTL and testbench

SPARSE_PAIR_SCHED -- requirements
Module: sparse_pair_sched

---
 rtl/sparse_pair_sched.sv | 187 ++++++++++++++++++
 tb/tb_sparse_pair_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_pair_sched.sv
// Sparse weight/input pair scheduler: walks weight-major over 4-lane input groups
// and flags which lanes form a legal product, with the output coordinate per lane.
module sparse_pair_sched #(
  parameter int unsigned LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [8:0][3:0]  comp_wt_ind,
  input  logic [15:0][3:0] comp_ip_ind,
  input  logic [3:0]       num_wt,
  input  logic [4:0]       num_ip,
  input  logic [4:0]       wt_size,
  input  logic [4:0]       ip_size,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       out_wt_sel,
  output logic [3:0]       out_ip_base,
  output logic [3:0]       out_lane_vld,
  output logic [3:0][3:0]  out_cords,
  output logic             busy,
  output logic             done,
  output logic [7:0]       pair_cnt
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned NUM_W  = 5;
  localparam int unsigned DIFF_W = 6;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned POP_W  = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             w_q, w_d;
  logic [1:0]             g_q, g_d;
  logic                   load;

  logic [8:0][IDX_W-1:0]  wt_q;
  logic [15:0][IDX_W-1:0] ip_q;
  logic [3:0]             nwt_q;
  logic [NUM_W-1:0]       nip_q, wsz_q, isz_q;

  logic [3:0]             nwt_in;
  logic [NUM_W-1:0]       nip_in;

  // Beat math reads the ports while a tile is being accepted, latched copies afterwards
  logic [8:0][IDX_W-1:0]  src_wt;
  logic [15:0][IDX_W-1:0] src_ip;
  logic [NUM_W-1:0]       src_nip, src_wsz, src_isz;

  logic [NUM_W-1:0]       grp_sum;
  logic [1:0]             last_g;
  logic [3:0]             last_w;
  logic [POP_W-1:0]       pop;

  logic [3:0]             j;
  logic signed [DIFF_W-1:0] diff, limit;

  logic                   valid_d;
  logic [3:0]             wt_sel_d, ip_base_d, lane_vld_d;
  logic [3:0][3:0]        cords_d;
  logic [CNT_W-1:0]       pair_d;

  assign nwt_in  = (num_wt > 4'd9)  ? 4'd9  : num_wt;
  assign nip_in  = (num_ip > 5'd16) ? 5'd16 : num_ip;
  assign grp_sum = nip_q + 5'd3;
  assign last_g  = 2'((grp_sum >> 2) - 5'd1);
  assign last_w  = nwt_q - 4'd1;

  always_comb begin
    src_wt  = wt_q;
    src_ip  = ip_q;
    src_nip = nip_q;
    src_wsz = wsz_q;
    src_isz = isz_q;
    if (state_q == IDLE) begin
      src_wt  = comp_wt_ind;
      src_ip  = comp_ip_ind;
      src_nip = nip_in;
      src_wsz = wt_size;
      src_isz = ip_size;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + POP_W'(out_lane_vld[i]);
  end

  // Next state, beat position and registered-output values
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    g_d        = g_q;
    load       = 1'b0;
    pair_d     = pair_cnt;
    lane_vld_d = '0;
    cords_d    = '0;
    j          = '0;
    diff       = '0;
    limit      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load   = 1'b1;
          pair_d = '0;
          w_d    = '0;
          g_d    = '0;
          state_d = ((nwt_in == 4'd0) || (nip_in == 5'd0)) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          pair_d = pair_cnt + CNT_W'(pop);
          if (g_q == last_g) begin
            g_d = '0;
            if (w_q == last_w) state_d = DONE;
            else               w_d = w_q + 4'd1;
          end else begin
            g_d = g_q + 2'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d   = (state_d == ISSUE);
    wt_sel_d  = valid_d ? w_d : 4'd0;
    ip_base_d = valid_d ? {g_d, 2'b00} : 4'd0;

    limit = $signed({1'b0, src_isz}) - $signed({1'b0, src_wsz});
    for (int i = 0; i < LANES; i++) begin
      j    = {g_d, 2'(i)};
      diff = $signed({2'b00, src_ip[j]}) - $signed({2'b00, src_wt[w_d]});
      if (valid_d && ({1'b0, j} < src_nip) && !diff[DIFF_W-1] && (diff <= limit)) begin
        lane_vld_d[i] = 1'b1;
        cords_d[i]    = diff[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      w_q          <= '0;
      g_q          <= '0;
      wt_q         <= '0;
      ip_q         <= '0;
      nwt_q        <= '0;
      nip_q        <= '0;
      wsz_q        <= '0;
      isz_q        <= '0;
      out_valid    <= 1'b0;
      out_wt_sel   <= '0;
      out_ip_base  <= '0;
      out_lane_vld <= '0;
      out_cords    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pair_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      g_q          <= g_d;
      out_valid    <= valid_d;
      out_wt_sel   <= wt_sel_d;
      out_ip_base  <= ip_base_d;
      out_lane_vld <= lane_vld_d;
      out_cords    <= cords_d;
      busy         <= (state_d != IDLE);
      done         <= (state_d == DONE);
      pair_cnt     <= pair_d;
      if (load) begin
        wt_q  <= comp_wt_ind;
        ip_q  <= comp_ip_ind;
        nwt_q <= nwt_in;
        nip_q <= nip_in;
        wsz_q <= wt_size;
        isz_q <= ip_size;
      end
    end
  end

endmodule

// File: tb/tb_sparse_pair_sched.sv
// Randomized and directed bench for sparse_pair_sched against a rule-level tile model.
module tb_sparse_pair_sched;

  logic             clk = 1'b0;
  logic             rst, start, out_ready;
  logic [8:0][3:0]  comp_wt_ind;
  logic [15:0][3:0] comp_ip_ind;
  logic [3:0]       num_wt;
  logic [4:0]       num_ip, wt_size, ip_size;
  logic             out_valid, busy, done;
  logic [3:0]       out_wt_sel, out_ip_base, out_lane_vld;
  logic [3:0][3:0]  out_cords;
  logic [7:0]       pair_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int last_pair;

  int m_wt[9];
  int m_ip[16];
  int m_nwt, m_nip, m_wsz, m_isz;

  sparse_pair_sched #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .comp_wt_ind(comp_wt_ind), .comp_ip_ind(comp_ip_ind),
    .num_wt(num_wt), .num_ip(num_ip), .wt_size(wt_size), .ip_size(ip_size),
    .out_ready(out_ready), .out_valid(out_valid), .out_wt_sel(out_wt_sel),
    .out_ip_base(out_ip_base), .out_lane_vld(out_lane_vld), .out_cords(out_cords),
    .busy(busy), .done(done), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  // Expected {wt_sel, ip_base, lane_vld, cords} for beat b of the model tile
  function automatic logic [27:0] model_beat(input int b);
    int nip, groups, w, g, jj, d;
    logic [3:0]  v;
    logic [15:0] c;
    nip = (m_nip > 16) ? 16 : m_nip;
    groups = (nip + 3) / 4;
    w = b / groups;
    g = b % groups;
    v = '0;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      jj = 4 * g + i;
      if (jj < nip) begin
        d = m_ip[jj] - m_wt[w];
        if (d >= 0 && d <= m_isz - m_wsz) begin
          v[i] = 1'b1;
          c[4*i +: 4] = 4'(d);
        end
      end
    end
    return {4'(w), 4'(4 * g), v, c};
  endfunction

  task automatic load_dut();
    for (int k = 0; k < 9; k++)  comp_wt_ind[k] = 4'(m_wt[k]);
    for (int k = 0; k < 16; k++) comp_ip_ind[k] = 4'(m_ip[k]);
    num_wt  = 4'(m_nwt);
    num_ip  = 5'(m_nip);
    wt_size = 5'(m_wsz);
    ip_size = 5'(m_isz);
  endtask

  task automatic scramble_dut();
    for (int k = 0; k < 9; k++)  comp_wt_ind[k] = 4'($urandom);
    for (int k = 0; k < 16; k++) comp_ip_ind[k] = 4'($urandom);
    num_wt  = 4'($urandom);
    num_ip  = 5'($urandom);
    wt_size = 5'($urandom);
    ip_size = 5'($urandom);
  endtask

  // mode 0: always ready, 1: random ready, 2: three stall cycles on beat 1
  task automatic run_tile(input int mode, input string tag);
    int nwt, nip, nb, beat, cyc, stall, exp_pair;
    logic [28:0] obs, expv;
    logic rdy;
    nwt = (m_nwt > 9) ? 9 : m_nwt;
    nip = (m_nip > 16) ? 16 : m_nip;
    nb  = nwt * ((nip + 3) / 4);
    @(negedge clk);
    load_dut();
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_dut();
    exp_pair = 0; beat = 0; cyc = 0; stall = 0;
    while (beat < nb && cyc < 400) begin
      obs  = {out_valid, out_wt_sel, out_ip_base, out_lane_vld, out_cords};
      expv = {1'b1, model_beat(beat)};
      n_checks++;
      if (obs !== expv) $display("FAIL %s beat%0d: got %h want %h", tag, beat, obs, expv);
      else n_pass++;
      n_checks++;
      if ({busy, done, pair_cnt} !== {1'b1, 1'b0, 8'(exp_pair)})
        $display("FAIL %s pair/busy beat%0d: got %b %b %0d want 1 0 %0d", tag, beat, busy, done, pair_cnt, exp_pair);
      else n_pass++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(beat == 1 && stall < 3);
      endcase
      if (beat == 1 && !rdy) stall++;
      out_ready = rdy;
      start = 1'($urandom_range(0, 1));
      if (rdy) begin
        exp_pair += $countones(expv[19:16]);
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    if (beat < nb) begin
      n_checks++;
      $display("FAIL %s timeout: got %0d beats want %0d", tag, beat, nb);
    end
    start = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    n_checks++;
    if ({out_valid, busy, done, pair_cnt} !== {3'b011, 8'(exp_pair)})
      $display("FAIL %s done cycle: got v%b b%b d%b p%0d want v0 b1 d1 p%0d", tag, out_valid, busy, done, pair_cnt, exp_pair);
    else n_pass++;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({out_valid, busy, done, pair_cnt} !== {3'b000, 8'(exp_pair)})
      $display("FAIL %s idle after: got v%b b%b d%b p%0d want v0 b0 d0 p%0d", tag, out_valid, busy, done, pair_cnt, exp_pair);
    else n_pass++;
    last_pair = exp_pair;
  endtask

  task automatic set_scenario1();
    m_wt = '{2, 1, 1, 0, 0, 0, 0, 0, 0};
    m_ip = '{2, 4, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    m_nwt = 5; m_nip = 4; m_wsz = 3; m_isz = 4;
  endtask

  task automatic set_scenario4();
    m_wt = '{default: 0};
    m_ip = '{default: 0};
    m_nwt = 9; m_nip = 16; m_wsz = 1; m_isz = 16;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, busy, done, out_wt_sel, out_ip_base, out_lane_vld, out_cords, pair_cnt} !== 39'd0)
      $display("FAIL reset: got v%b b%b d%b w%h g%h l%h c%h p%0d want all 0", out_valid, busy, done,
               out_wt_sel, out_ip_base, out_lane_vld, out_cords, pair_cnt);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_scenario1();
    set_scenario1();
    run_tile(0, "scn1");
    n_checks++;
    if (last_pair != 7 || pair_cnt !== 8'd7) $display("FAIL scn1 total: got %0d want 7", pair_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    set_scenario1();
    run_tile(2, "stall");
  endtask

  task automatic test_empty_tile();
    set_scenario1();
    m_nip = 0;
    run_tile(0, "empty_ip");
    m_nip = 4; m_nwt = 0;
    run_tile(0, "empty_wt");
  endtask

  task automatic test_full_tile();
    set_scenario4();
    run_tile(1, "full");
    n_checks++;
    if (pair_cnt !== 8'd144) $display("FAIL full total: got %0d want 144", pair_cnt);
    else n_pass++;
  endtask

  task automatic test_partial_group();
    m_wt = '{default: 0};
    m_ip = '{0, 1, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    m_nwt = 1; m_nip = 6; m_wsz = 1; m_isz = 8;
    run_tile(0, "partial");
    n_checks++;
    if (pair_cnt !== 8'd6) $display("FAIL partial total: got %0d want 6", pair_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_tile();
    int seen_done;
    set_scenario4();
    @(negedge clk);
    load_dut();
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, out_wt_sel, out_ip_base} !== {1'b1, 4'd0, 4'd8})
      $display("FAIL midrst beat2: got v%b w%0d g%0d want v1 w0 g8", out_valid, out_wt_sel, out_ip_base);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({out_valid, busy, done, out_wt_sel, out_ip_base, out_lane_vld, out_cords, pair_cnt} !== 39'd0)
      $display("FAIL midrst zero: got v%b b%b d%b w%h g%h l%h c%h p%0d want all 0", out_valid, busy, done,
               out_wt_sel, out_ip_base, out_lane_vld, out_cords, pair_cnt);
    else n_pass++;
    seen_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) $display("FAIL midrst quiet: got %0d active cycles want 0", seen_done);
    else n_pass++;
    run_tile(0, "after_rst");
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 9; k++)  m_wt[k] = $urandom_range(0, 15);
      for (int k = 0; k < 16; k++) m_ip[k] = $urandom_range(0, 15);
      m_nwt = $urandom_range(0, 15);
      m_nip = $urandom_range(0, 31);
      m_wsz = $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) m_isz = $urandom_range(0, 31);
      else m_isz = m_wsz + $urandom_range(0, 31 - m_wsz);
      run_tile(1, "random");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    comp_wt_ind = '0; comp_ip_ind = '0;
    num_wt = '0; num_ip = '0; wt_size = '0; ip_size = '0;
    test_reset();
    test_scenario1();
    test_backpressure();
    test_empty_tile();
    test_full_tile();
    test_partial_group();
    test_reset_mid_tile();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
